// File: rtl/mac_array_acc_pkg.sv
// Shared widths, saturation bounds and beat-control payload for the MAC array accumulator.
package mac_array_acc_pkg;

  localparam int unsigned BW_DEF      = 4;
  localparam int unsigned COL_DEF     = 8;
  localparam int unsigned PSUM_BW_DEF = 16;

  localparam int unsigned PROD_BW = 2 * BW_DEF + 1;
  localparam int unsigned TREE_BW = PROD_BW + $clog2(COL_DEF);

  localparam logic [PSUM_BW_DEF-1:0] SAT_MAX = {1'b0, {(PSUM_BW_DEF-1){1'b1}}};
  localparam logic [PSUM_BW_DEF-1:0] SAT_MIN = {1'b1, {(PSUM_BW_DEF-1){1'b0}}};

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } beat_ctrl_t;

  function automatic int unsigned prod_bw_f(int unsigned b);
    return 2 * b + 1;
  endfunction

  function automatic int unsigned tree_bw_f(int unsigned b, int unsigned c);
    return prod_bw_f(b) + $clog2(c);
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One lane multiplier: unsigned or signed activation times signed weight.
module mac_lane
  import mac_array_acc_pkg::*;
#(
  parameter int unsigned bw = BW_DEF
) (
  input  logic                           mode,
  input  logic        [bw-1:0]           x,
  input  logic        [bw-1:0]           w,
  output logic signed [prod_bw_f(bw)-1:0] prod_c
);

  localparam int unsigned P_W = prod_bw_f(bw);

  logic signed [P_W-1:0] xe;
  logic signed [P_W-1:0] we;

  always_comb begin
    if (mode) begin
      xe = P_W'($signed(x));
    end else begin
      xe = P_W'(x);
    end
    we     = P_W'($signed(w));
    prod_c = xe * we;
  end

endmodule

// File: rtl/mac_array_acc.sv
// Pipelined col-lane MAC: products, registered adder tree, then per-vector accumulate with optional clamp.
module mac_array_acc
  import mac_array_acc_pkg::*;
#(
  parameter int unsigned bw      = BW_DEF,
  parameter int unsigned psum_bw = PSUM_BW_DEF,
  parameter int unsigned col     = COL_DEF,
  parameter bit          sat     = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  input  logic                first,
  input  logic                last,
  input  logic                mode,
  input  logic [col*bw-1:0]   x,
  input  logic [col*bw-1:0]   w,
  input  logic [psum_bw-1:0]  psum_in,
  output logic [psum_bw-1:0]  out,
  output logic                out_valid,
  output logic                ovf
);

  localparam int unsigned P_W  = prod_bw_f(bw);
  localparam int unsigned T_W  = tree_bw_f(bw, col);
  localparam int unsigned LVLS = $clog2(col);
  localparam int unsigned A_W  = psum_bw + 1;

  localparam logic [psum_bw-1:0] MAX_V = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] MIN_V = {1'b1, {(psum_bw-1){1'b0}}};

  // Stage P: lane products with flags and seed alongside
  logic signed [P_W-1:0]     prod_c [col];
  logic signed [P_W-1:0]     prod_q [col];
  beat_ctrl_t                ctrl_p;
  logic signed [psum_bw-1:0] seed_p;

  for (genvar i = 0; i < col; i++) begin : g_lane
    mac_lane #(.bw(bw)) u_lane (
      .mode   (mode),
      .x      (x[i*bw +: bw]),
      .w      (w[i*bw +: bw]),
      .prod_c (prod_c[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_p <= '0;
      seed_p <= '0;
      for (int i = 0; i < col; i++) prod_q[i] <= '0;
    end else begin
      ctrl_p <= '{valid: in_valid, first: in_valid & first, last: in_valid & last};
      seed_p <= psum_in;
      for (int i = 0; i < col; i++) prod_q[i] <= prod_c[i];
    end
  end

  // Stage T: level l holds 2^l nodes; level LVLS is the sign-extended products
  for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
    logic signed [T_W-1:0] nd [1<<l];
    if (l == LVLS) begin : g_leaf
      for (genvar j = 0; j < (1 << l); j++) begin : g_n
        assign nd[j] = T_W'(prod_q[j]);
      end
    end else begin : g_add
      for (genvar j = 0; j < (1 << l); j++) begin : g_n
        assign nd[j] = g_lvl[l+1].nd[2*j] + g_lvl[l+1].nd[2*j+1];
      end
    end
  end

  logic signed [T_W-1:0]     tree_q;
  beat_ctrl_t                ctrl_t;
  logic signed [psum_bw-1:0] seed_t;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tree_q <= '0;
      ctrl_t <= '0;
      seed_t <= '0;
    end else begin
      tree_q <= g_lvl[0].nd[0];
      ctrl_t <= ctrl_p;
      seed_t <= seed_p;
    end
  end

  // Stage A: one guard bit exposes overflow of the accumulate step
  logic signed [psum_bw-1:0] acc_q;
  logic                      sticky_q;
  logic signed [A_W-1:0]     base_c;
  logic signed [A_W-1:0]     sum_c;
  logic signed [A_W-1:0]     res_c;
  logic                      ovf_c;
  logic                      sticky_c;
  logic signed [psum_bw-1:0] acc_c;

  always_comb begin
    base_c   = ctrl_t.first ? A_W'(seed_t) : A_W'(acc_q);
    sum_c    = A_W'(tree_q);
    res_c    = base_c + sum_c;
    ovf_c    = res_c[A_W-1] ^ res_c[A_W-2];
    acc_c    = res_c[psum_bw-1:0];
    if (ovf_c && sat) begin
      acc_c = res_c[A_W-1] ? MIN_V : MAX_V;
    end
    sticky_c = (ctrl_t.first ? 1'b0 : sticky_q) | ovf_c;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q     <= '0;
      sticky_q  <= 1'b0;
      out       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (ctrl_t.valid) begin
        acc_q    <= acc_c;
        sticky_q <= sticky_c;
        if (ctrl_t.last) begin
          out       <= acc_c;
          ovf       <= sticky_c;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/mac_array_acc.md
# mac_array_acc

Parametrised, pipelined successor to the four-lane MAC wrapper. It multiplies `col` activation/weight pairs per beat, reduces them through a registered adder tree, and accumulates the result over a multi-beat vector delimited by `first`/`last` flags. It emits one `psum_bw` partial sum per vector with optional saturation. It sits between the activation/weight feeders and the partial-sum writeback path of a systolic column.

## Interface
- `bw`, 4: activation and weight width.
- `psum_bw`, 16: partial-sum and accumulator width. Must satisfy psum_bw ≥ 2*bw+1+log2(col).
- `col`, 8: lanes per beat. Must be a power of two, ≥2.
- `sat`, 1: 1 clamps the accumulator to the signed psum range; 0 wraps modulo 2^psum_bw.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: beat present this cycle.
- `first` input 1: beat starts a new vector. Qualified by `in_valid`.
- `last` input 1: beat ends the vector. Qualified by `in_valid`.
- `mode` input 1: 0 = unsigned x × signed w; 1 = signed x × signed w. Sampled per beat.
- `x` input col*bw: packed activations; lane i is x[i*bw +: bw].
- `w` input col*bw: packed weights, same packing as `x`.
- `psum_in` input psum_bw: signed seed, added on the `first` beat only.
- `out` output psum_bw: final vector sum. Held until the next result.
- `out_valid` output 1: one-cycle pulse when `out` updates.
- `ovf` output 1: the vector just reported saturated or wrapped at least once. Valid with `out`.

## Operation
- **Stage 1 (P).** Each lane forms a (2*bw+1)-bit signed product.
  - mode=0: x zero-extended to bw+1 bits.
  - mode=1: x sign-extended to bw+1 bits.
  - w is always signed.
  - `first`, `last`, `in_valid` and `psum_in` are registered alongside the products.
- **Stage 2 (T).** Full combinational reduction tree of `col` products into a (2*bw+1+log2 col)-bit sum, then registered. No overflow is possible inside the tree.
- **Stage 3 (A).** The tree sum is sign-extended to psum_bw+1 bits, then:
  - Valid beat with `first`: acc ← sum + psum_in; the sticky overflow flag is cleared, then set from this add.
  - Valid beat without `first`: acc ← acc + sum.
  - Overflow: the psum_bw+1-bit result falls outside [−2^(psum_bw−1), 2^(psum_bw−1)−1]. With sat=1 the result clamps to the nearest bound; with sat=0 it wraps. Either way the sticky flag is set.
  - Valid beat with `last`: out ← new acc value, ovf ← new sticky value, out_valid=1 for one cycle.
- **Bubbles.** in_valid=0 beats propagate as bubbles. They leave acc, out and the sticky flag unchanged, and `first`/`last` are ignored on them.
- **first and last together** form a single-beat vector: out = sum + psum_in.
- **first without a preceding last** abandons the in-progress accumulation silently. No output is produced for the abandoned vector.
- **Valid beat with neither flag and no open vector** (e.g. after reset) accumulates onto acc, which reset leaves at 0.

## Timing
- Throughput: one beat per cycle, no backpressure.
- Latency: a `last` beat sampled at edge E0 produces out_valid=1 and the new `out`/`ovf` after edge E0+2. This latency is fixed and independent of `col`.
- Reset (asynchronous on reset_n falling; released synchronously to clk by the integrator):
  - All pipeline valids, acc, sticky flag, out, ovf and out_valid go to 0.
  - A vector in flight at reset is discarded with no output.
  - The first beat sampled after release is treated normally.

## Structure
- Shared package constants:
  - `PROD_BW` = 2*bw+1
  - `TREE_BW` = PROD_BW+log2(col)
  - the saturation bounds as psum_bw-wide localparams
- One natural sub-module: `mac_lane`, the mode-aware signed/unsigned bw×bw multiplier, instantiated `col` times in a generate loop.
- The adder tree is a generate-built level structure inside the top module, not per-adder instances.

## Test plan
Defaults: bw=4, col=8, psum_bw=16.
1. Single beat, first=last=1, all x=1, all w=2, psum_in=100, mode=1 → out=116, ovf=0, out_valid pulses 2 cycles after the sampling edge.
2. All x=4'hF, all w=3, single beat, psum_in=0 → mode=1 gives out=−24; mode=0 gives out=360.
3. Four beats (first on beat 0, last on beat 3) with two bubbles inserted, each beat x=2, w=1, psum_in=5 → one out_valid pulse, out=69. `out` holds its value afterward.
4. sat=1: psum_in=32760, single beat with x=7, w=7 (sum 392) → out=32767, ovf=1. Rerun with sat=0 → out=−32384, ovf=1. The next normal vector reports ovf=0.
5. Two back-to-back single-beat vectors (sums 16 and 24) → out_valid on two consecutive cycles with values 16 then 24. A `first` arriving mid-vector drops the old vector with no pulse.
6. Assert reset_n=0 mid-vector, between the `first` and `last` beats → out, ovf, out_valid read 0 immediately (asynchronously). A post-reset single beat (sum 8, psum_in 0) → out=8.
